control_unit: RTL
=================

# control_unit

Control FSM for the RISC SPM core. It consumes `instr` and `z_flag` from the datapath and drives every datapath control input: register loads, PC load and increment, bus mux selects, Y/Z/address loads and memory write. It sequences each instruction through fetch, decode and execute states and stops in HALT on an illegal opcode.

## Interface
- No parameters. Widths are fixed by the datapath.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in 8: IR contents. opcode=`instr[7:4]`, src=`instr[3:2]`, dest=`instr[1:0]`.
- `z_flag` in 1: registered zero flag.
- `load_ir`, `load_pc`, `inc_pc` out 1 each: IR load, PC load and PC increment.
- `load_r0`..`load_r3` out 1 each: general-purpose register loads.
- `sel_mux1` out 3: bus1 source. 0..3 = R0..R3, 4 = PC.
- `sel_mux2` out 2: bus2 source. 0 = alu_out, 1 = bus1, 2 = m_out.
- `load_y`, `load_z`, `load_addr`, `write` out 1 each.
- `halted` out 1: high while in S_HALT.

## Operation
Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8. Opcodes 9–15 are illegal.

Outputs are combinational from state and `instr`. Any output not listed for a state is 0.

- S_IDLE: all outputs 0. Next state S_FET1.
- S_FET1: sel_mux1=PC, sel_mux2=bus1, load_addr, inc_pc. Next S_FET2.
- S_FET2: sel_mux2=m_out, load_ir. Next S_DEC.
- S_DEC, decoded by opcode:
  - NOP: no outputs. Next S_FET1.
  - ADD/SUB/AND: sel_mux1=src, sel_mux2=bus1, load_y. Next S_EX1.
  - NOT: sel_mux1=src, sel_mux2=alu_out, load_z, load_r[dest]. Next S_FET1.
  - RD/WR/BR: sel_mux1=PC, sel_mux2=bus1, load_addr. Next S_RD1 / S_WR1 / S_BR1 respectively.
  - BRZ with z_flag=1: same as BR. Next S_BR1.
  - BRZ with z_flag=0: inc_pc only, which skips the operand byte. Next S_FET1.
  - Illegal opcode: no outputs. Next S_HALT.
- S_EX1: sel_mux1=dest, sel_mux2=alu_out, load_z, load_r[dest]. Next S_FET1.
- S_RD1: sel_mux2=m_out, load_addr, inc_pc. Next S_RD2.
- S_RD2: sel_mux2=m_out, load_r[dest]. Next S_FET1.
- S_WR1: sel_mux2=m_out, load_addr, inc_pc. Next S_WR2.
- S_WR2: sel_mux1=src, write. Next S_FET1.
- S_BR1: sel_mux2=m_out, load_addr. Next S_BR2.
- S_BR2: sel_mux2=m_out, load_pc. Next S_FET1.
- S_HALT: all outputs 0 except `halted`=1. Stays in S_HALT until reset.

Invariants:
- At most one `load_rN` is high in any cycle.
- `load_pc` and `inc_pc` are never high together.

## Timing
- Reset: state goes to S_IDLE asynchronously.
  - All outputs are 0 while `rst_n` is low and during the S_IDLE cycle.
  - `sel_mux1`=0 and `sel_mux2`=0 in reset.
- Reset asserted in any state, mid-instruction: abandons the instruction with no further loads. Operation restarts with S_IDLE, then S_FET1.
- Cycles from S_FET1 to the next S_FET1:
  - NOP, NOT, BRZ not taken: 3.
  - ADD, SUB, AND: 4.
  - RD, WR, BR, BRZ taken: 5.
- `instr` is sampled only in S_DEC and the execute states. IR is stable from the cycle after S_FET2.
- `z_flag` is sampled only in S_DEC for BRZ. It reflects the last ALU instruction.

## Configuration
- `CTRL_INSTR_CNT_EN` defined:
  - Adds output `instr_cnt` [15:0], reset 0.
  - Increments by 1 on every transition into S_FET1 except the one from S_IDLE.
  - Wraps 0xFFFF→0x0000.
  - Holds in S_HALT.
- Undefined: no port and no counter logic. FSM behaviour is identical either way.

## Structure
- Shared package `risc_spm_pkg` holds:
  - the opcode constants;
  - the state enumeration (binary encoded, 4 bits);
  - the `sel_mux1` / `sel_mux2` select constants.
- The datapath mux models reference the same select constants.
- Single module with no sub-module. The `dest`/`src` field to `load_rN` decode is inline.

## Test plan
- Reset mid-RD: assert `rst_n`=0 in S_RD1 → all outputs 0 at once. After release: one S_IDLE cycle, then `load_addr`=1, `inc_pc`=1, `sel_mux1`=4.
- NOT R1→R2 (`instr`=0x46) → in S_DEC: `sel_mux1`=1, `sel_mux2`=0, `load_z`=1, `load_r2`=1. Next cycle is S_FET1; 3 cycles total.
- SUB R3,R0 (`instr`=0x2C) → S_DEC: `sel_mux1`=3, `load_y`. S_EX1: `sel_mux1`=0, `load_r0`, `load_z`. 4 cycles total.
- WR from R2 (`instr`=0x68) → `write`=1 only in S_WR2, with `sel_mux1`=2. `inc_pc` is high in S_FET1 and S_WR1 only.
- BRZ (`instr`=0x80):
  - `z_flag`=0 → S_DEC asserts `inc_pc` only; 3 cycles.
  - `z_flag`=1 → `load_pc` in S_BR2; 5 cycles.
- Opcode 0xF0 → S_HALT. `halted`=1 and all other outputs stay 0 for 100 cycles. With `CTRL_INSTR_CNT_EN`, `instr_cnt` is unchanged.

Source files
------------

// File: rtl/risc_spm_pkg.sv
// Shared definitions for the RISC SPM core: opcodes, control-unit state
// encoding, and the bus mux select codes used by both the control unit
// and the datapath mux models.
package risc_spm_pkg;

   // Instruction opcodes (instr[7:4]); 9..15 are illegal and halt the core
   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_NOT = 4'd4;
   localparam logic [3:0] OP_RD  = 4'd5;
   localparam logic [3:0] OP_WR  = 4'd6;
   localparam logic [3:0] OP_BR  = 4'd7;
   localparam logic [3:0] OP_BRZ = 4'd8;

   // bus1 source select: 0..3 pick R0..R3 directly from the register field
   localparam logic [2:0] SEL1_R0 = 3'd0;
   localparam logic [2:0] SEL1_PC = 3'd4;

   // bus2 source select
   localparam logic [1:0] SEL2_ALU  = 2'd0;
   localparam logic [1:0] SEL2_BUS1 = 2'd1;
   localparam logic [1:0] SEL2_MEM  = 2'd2;

   // Control-unit states, binary encoded
   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_FET1 = 4'd1,
      S_FET2 = 4'd2,
      S_DEC  = 4'd3,
      S_EX1  = 4'd4,
      S_RD1  = 4'd5,
      S_RD2  = 4'd6,
      S_WR1  = 4'd7,
      S_WR2  = 4'd8,
      S_BR1  = 4'd9,
      S_BR2  = 4'd10,
      S_HALT = 4'd11
   } state_e;

endpackage

// File: rtl/control_unit.sv
// Control FSM for the RISC SPM core. Sequences fetch, decode and execute
// and drives every datapath control; outputs are combinational from the
// current state and the IR contents. Illegal opcodes park the FSM in HALT.
// Optional macro CTRL_INSTR_CNT_EN adds a 16-bit retired-instruction
// counter on output instr_cnt.
module control_unit
   import risc_spm_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  instr,
   input  logic        z_flag,
   output logic        load_ir,
   output logic        load_pc,
   output logic        inc_pc,
   output logic        load_r0,
   output logic        load_r1,
   output logic        load_r2,
   output logic        load_r3,
   output logic [2:0]  sel_mux1,
   output logic [1:0]  sel_mux2,
   output logic        load_y,
   output logic        load_z,
   output logic        load_addr,
   output logic        write,
   output logic        halted
`ifdef CTRL_INSTR_CNT_EN
   ,
   output logic [15:0] instr_cnt
`endif
);

   state_e     state_q, state_d;
   logic [3:0] opcode;
   logic [1:0] src, dest;
   logic [3:0] load_r;

   assign opcode = instr[7:4];
   assign src    = instr[3:2];
   assign dest   = instr[1:0];

   assign load_r0 = load_r[0];
   assign load_r1 = load_r[1];
   assign load_r2 = load_r[2];
   assign load_r3 = load_r[3];

   // Next-state selection and control decode for the current state
   always_comb begin
      state_d   = state_q;
      load_ir   = 1'b0;
      load_pc   = 1'b0;
      inc_pc    = 1'b0;
      load_r    = '0;
      sel_mux1  = SEL1_R0;
      sel_mux2  = SEL2_ALU;
      load_y    = 1'b0;
      load_z    = 1'b0;
      load_addr = 1'b0;
      write     = 1'b0;
      halted    = 1'b0;

      case (state_q)
         S_IDLE: state_d = S_FET1;

         S_FET1: begin
            sel_mux1  = SEL1_PC;
            sel_mux2  = SEL2_BUS1;
            load_addr = 1'b1;
            inc_pc    = 1'b1;
            state_d   = S_FET2;
         end

         S_FET2: begin
            sel_mux2 = SEL2_MEM;
            load_ir  = 1'b1;
            state_d  = S_DEC;
         end

         S_DEC: begin
            case (opcode)
               OP_NOP: state_d = S_FET1;

               OP_ADD, OP_SUB, OP_AND: begin
                  sel_mux1 = {1'b0, src};
                  sel_mux2 = SEL2_BUS1;
                  load_y   = 1'b1;
                  state_d  = S_EX1;
               end

               OP_NOT: begin
                  sel_mux1     = {1'b0, src};
                  sel_mux2     = SEL2_ALU;
                  load_z       = 1'b1;
                  load_r[dest] = 1'b1;
                  state_d      = S_FET1;
               end

               // Memory and branch ops first point the address register at
               // the operand byte that follows the opcode
               OP_RD, OP_WR, OP_BR: begin
                  sel_mux1  = SEL1_PC;
                  sel_mux2  = SEL2_BUS1;
                  load_addr = 1'b1;
                  if (opcode == OP_RD)
                     state_d = S_RD1;
                  else if (opcode == OP_WR)
                     state_d = S_WR1;
                  else
                     state_d = S_BR1;
               end

               // Untaken BRZ steps the PC past its operand byte
               OP_BRZ: begin
                  if (z_flag) begin
                     sel_mux1  = SEL1_PC;
                     sel_mux2  = SEL2_BUS1;
                     load_addr = 1'b1;
                     state_d   = S_BR1;
                  end else begin
                     inc_pc  = 1'b1;
                     state_d = S_FET1;
                  end
               end

               default: state_d = S_HALT;
            endcase
         end

         S_EX1: begin
            sel_mux1     = {1'b0, dest};
            sel_mux2     = SEL2_ALU;
            load_z       = 1'b1;
            load_r[dest] = 1'b1;
            state_d      = S_FET1;
         end

         S_RD1: begin
            sel_mux2  = SEL2_MEM;
            load_addr = 1'b1;
            inc_pc    = 1'b1;
            state_d   = S_RD2;
         end

         S_RD2: begin
            sel_mux2     = SEL2_MEM;
            load_r[dest] = 1'b1;
            state_d      = S_FET1;
         end

         S_WR1: begin
            sel_mux2  = SEL2_MEM;
            load_addr = 1'b1;
            inc_pc    = 1'b1;
            state_d   = S_WR2;
         end

         S_WR2: begin
            sel_mux1 = {1'b0, src};
            write    = 1'b1;
            state_d  = S_FET1;
         end

         S_BR1: begin
            sel_mux2  = SEL2_MEM;
            load_addr = 1'b1;
            state_d   = S_BR2;
         end

         S_BR2: begin
            sel_mux2 = SEL2_MEM;
            load_pc  = 1'b1;
            state_d  = S_FET1;
         end

         S_HALT: begin
            halted  = 1'b1;
            state_d = S_HALT;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State register; reset abandons any instruction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

`ifdef CTRL_INSTR_CNT_EN
   logic [15:0] instr_cnt_q;

   // Count instruction boundaries: every entry to FET1 except the first
   // one out of IDLE. HALT never re-enters FET1, so the count holds there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         instr_cnt_q <= '0;
      else if (state_d == S_FET1 && state_q != S_IDLE)
         instr_cnt_q <= instr_cnt_q + 16'd1;
   end

   assign instr_cnt = instr_cnt_q;
`endif

endmodule
